life_gen_writer: RTL and testbench



---
 rtl/life_gen_writer_pkg.sv | 30 +++
 rtl/life_gen_writer_neighbor_addr.sv | 46 ++++
 rtl/life_gen_writer.sv | 184 ++++++++++++++++++
 tb/tb_life_gen_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/life_gen_writer_pkg.sv
// Shared constants and types for the Game-of-Life generation writer.
package life_pkg;

    localparam int unsigned GRID_W   = 80;
    localparam int unsigned GRID_H   = 60;
    localparam int unsigned CELLS    = GRID_W * GRID_H;
    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned NB_COUNT = 9;

    localparam logic [3:0] P_LAST_READ = 4'd8;
    // The k=4 read (the cell itself) returns one cycle after it is issued.
    localparam logic [3:0] P_SELF      = 4'd5;
    localparam logic [3:0] P_WRITE     = 4'd10;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

    typedef enum logic [1:0] {D_NEG, D_ZERO, D_POS} delta_e;

    typedef struct packed {
        delta_e dy;
        delta_e dx;
    } nb_off_t;

    localparam nb_off_t NB_OFFSETS [NB_COUNT] = '{
        '{dy: D_NEG,  dx: D_NEG},  '{dy: D_NEG,  dx: D_ZERO}, '{dy: D_NEG,  dx: D_POS},
        '{dy: D_ZERO, dx: D_NEG},  '{dy: D_ZERO, dx: D_ZERO}, '{dy: D_ZERO, dx: D_POS},
        '{dy: D_POS,  dx: D_NEG},  '{dy: D_POS,  dx: D_ZERO}, '{dy: D_POS,  dx: D_POS}
    };

endpackage

// File: rtl/life_gen_writer_neighbor_addr.sv
// Combinational neighbour address: (x, y, k) -> toroidally wrapped y*GRID_W+x,
// using the running row base of y instead of a multiplier.
module life_neighbor_addr #(
    parameter int unsigned GRID_W = life_pkg::GRID_W,
    parameter int unsigned GRID_H = life_pkg::GRID_H,
    parameter int unsigned ADDR_W = life_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] x_i,
    input  logic [ADDR_W-1:0] y_i,
    input  logic [ADDR_W-1:0] row_base_i,
    input  logic [3:0]        k_i,
    output logic [ADDR_W-1:0] addr_o
);
    import life_pkg::*;

    localparam logic [ADDR_W-1:0] X_MAX    = ADDR_W'(GRID_W - 1);
    localparam logic [ADDR_W-1:0] Y_MAX    = ADDR_W'(GRID_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(GRID_W);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'((GRID_H - 1) * GRID_W);

    nb_off_t           off;
    logic [ADDR_W-1:0] nx;
    logic [ADDR_W-1:0] row;

    always_comb begin
        off = '{dy: D_ZERO, dx: D_ZERO};
        if (k_i < 4'(NB_COUNT)) begin
            off = NB_OFFSETS[k_i];
        end

        case (off.dx)
            D_NEG:   nx = (x_i == '0) ? X_MAX : x_i - 1'b1;
            D_POS:   nx = (x_i == X_MAX) ? '0 : x_i + 1'b1;
            default: nx = x_i;
        endcase

        case (off.dy)
            D_NEG:   row = (y_i == '0) ? LAST_ROW : row_base_i - ROW_STEP;
            D_POS:   row = (y_i == Y_MAX) ? '0 : row_base_i + ROW_STEP;
            default: row = row_base_i;
        endcase

        addr_o = row + nx;
    end

endmodule

// File: rtl/life_gen_writer.sv
// Sweeps the grid once per start, reading 9 neighbours per cell over an
// 11-cycle slot and writing the next-generation state to the destination buffer.
module life_gen_writer #(
    parameter int unsigned GRID_W = life_pkg::GRID_W,
    parameter int unsigned GRID_H = life_pkg::GRID_H,
    parameter int unsigned ADDR_W = life_pkg::ADDR_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic [15:0]       gen_count
);
    import life_pkg::*;

    localparam logic [ADDR_W-1:0] X_MAX    = ADDR_W'(GRID_W - 1);
    localparam logic [ADDR_W-1:0] Y_MAX    = ADDR_W'(GRID_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(GRID_W);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] x_q, x_d;
    logic [ADDR_W-1:0] y_q, y_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] cell_q, cell_d;
    logic [3:0]        phase_q, phase_d;
    logic [3:0]        n_q, n_d;
    logic              self_q, self_d;
    logic [15:0]       gen_q, gen_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] nb_addr;

    // Outputs are registered, so the address is formed from next-state position.
    life_neighbor_addr #(
        .GRID_W(GRID_W),
        .GRID_H(GRID_H),
        .ADDR_W(ADDR_W)
    ) u_nb (
        .x_i       (x_d),
        .y_i       (y_d),
        .row_base_i(row_d),
        .k_i       (phase_d),
        .addr_o    (nb_addr)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        row_d   = row_q;
        cell_d  = cell_q;
        phase_d = phase_q;
        n_d     = n_q;
        self_d  = self_q;
        gen_d   = gen_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    x_d     = '0;
                    y_d     = '0;
                    row_d   = '0;
                    cell_d  = '0;
                    phase_d = '0;
                    n_d     = '0;
                    self_d  = 1'b0;
                end
            end

            SWEEP: begin
                if ((phase_q != 4'd0) && (phase_q <= P_LAST_READ + 4'd1)) begin
                    if (phase_q == P_SELF) begin
                        self_d = rd_data;
                    end else begin
                        n_d = n_q + {3'b000, rd_data};
                    end
                end

                if (phase_q == P_WRITE) begin
                    phase_d = '0;
                    n_d     = '0;
                    self_d  = 1'b0;
                    cell_d  = cell_q + 1'b1;
                    if (x_q == X_MAX) begin
                        x_d = '0;
                        if (y_q == Y_MAX) begin
                            y_d     = '0;
                            row_d   = '0;
                            state_d = DONE;
                            gen_d   = gen_q + 16'd1;
                        end else begin
                            y_d   = y_q + 1'b1;
                            row_d = row_q + ROW_STEP;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_d    = (state_d == SWEEP);
        done_d    = (state_d == DONE);
        rd_en_d   = (state_d == SWEEP) && (phase_d <= P_LAST_READ);
        wr_en_d   = (state_d == SWEEP) && (phase_d == P_WRITE);
        rd_addr_d = rd_en_d ? nb_addr : rd_addr_q;
        wr_addr_d = wr_en_d ? cell_d : wr_addr_q;
        wr_data_d = wr_en_d ? ((n_d == 4'd3) | (self_d & (n_d == 4'd2))) : wr_data_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            row_q     <= '0;
            cell_q    <= '0;
            phase_q   <= '0;
            n_q       <= '0;
            self_q    <= 1'b0;
            gen_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            row_q     <= row_d;
            cell_q    <= cell_d;
            phase_q   <= phase_d;
            n_q       <= n_d;
            self_q    <= self_d;
            gen_q     <= gen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_gen_writer.sv
// Directed bench for life_gen_writer on a 20x24 torus with a behavioural
// source/destination RAM pair.
module tb_life_gen_writer;

    localparam int unsigned TW     = 20;
    localparam int unsigned TH     = 24;
    localparam int unsigned TA     = 13;
    localparam int unsigned TCELLS = TW * TH;
    localparam int unsigned TLAT   = TCELLS * 11 + 1;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b1;
    logic          start   = 1'b0;
    logic          rd_data = 1'b0;
    logic          busy, done, rd_en, wr_en, wr_data;
    logic [TA-1:0] rd_addr, wr_addr;
    logic [15:0]   gen_count;

    logic        src     [TCELLS];
    logic        dst     [TCELLS];
    logic        expv    [TCELLS];
    int unsigned dst_tag [TCELLS];

    int unsigned sweep_id   = 0;
    int unsigned writes     = 0;
    int unsigned overlaps   = 0;
    int unsigned dones      = 0;
    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned w_snap;

    always #5 aclk = ~aclk;

    life_gen_writer #(
        .GRID_W(TW),
        .GRID_H(TH),
        .ADDR_W(TA)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .gen_count(gen_count)
    );

    always @(posedge aclk) begin
        if (rd_en) rd_data <= src[rd_addr];
        if (wr_en) begin
            dst[wr_addr]     <= wr_data;
            dst_tag[wr_addr] <= sweep_id;
            writes           <= writes + 1;
        end
    end

    always @(negedge aclk) begin
        if (rd_en && wr_en) overlaps <= overlaps + 1;
        if (done) dones <= dones + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned idx(input int unsigned x, input int unsigned y);
        return y * TW + x;
    endfunction

    task automatic src_fill(input logic v);
        for (int unsigned i = 0; i < TCELLS; i++) src[i] = v;
    endtask

    task automatic exp_fill(input logic v);
        for (int unsigned i = 0; i < TCELLS; i++) expv[i] = v;
    endtask

    task automatic src_hblinker();
        src_fill(1'b0);
        src[idx(10, 20)] = 1'b1;
        src[idx(11, 20)] = 1'b1;
        src[idx(12, 20)] = 1'b1;
    endtask

    task automatic exp_hblinker();
        exp_fill(1'b0);
        expv[idx(10, 20)] = 1'b1;
        expv[idx(11, 20)] = 1'b1;
        expv[idx(12, 20)] = 1'b1;
    endtask

    task automatic exp_vblinker();
        exp_fill(1'b0);
        expv[idx(11, 19)] = 1'b1;
        expv[idx(11, 20)] = 1'b1;
        expv[idx(11, 21)] = 1'b1;
    endtask

    task automatic check_grid(input string tag);
        int unsigned bad = 0;
        for (int unsigned i = 0; i < TCELLS; i++) begin
            if (dst_tag[i] != sweep_id || dst[i] !== expv[i]) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic run_sweep(input int unsigned restart_at);
        int unsigned cyc, w0, d0, o0;
        bit          seen;
        sweep_id++;
        w0 = writes;
        d0 = dones;
        o0 = overlaps;
        @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        cyc   = 1;
        seen  = 1'b0;
        check("busy_after_start", busy, 1);
        check("rd_en_first_cycle", rd_en, 1);
        check("rd_addr_cell0_k0", rd_addr, TCELLS - 1);
        check("wr_en_first_cycle", wr_en, 0);
        while (!seen && cyc <= TLAT + 20) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start = (cyc == restart_at);
                @(negedge aclk);
                cyc++;
            end
        end
        start = 1'b0;
        check("done_latency", seen ? cyc : 0, TLAT);
        check("busy_at_done", busy, 0);
        repeat (8) @(negedge aclk);
        check("writes_per_sweep", writes - w0, TCELLS);
        check("done_pulses", dones - d0, 1);
        check("rd_wr_overlap", overlaps - o0, 0);
        check("rd_en_idle", rd_en, 0);
    endtask

    initial begin
        #2 aresetn = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_gen_count", gen_count, 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        src_fill(1'b0);
        exp_fill(1'b0);
        run_sweep(0);
        check_grid("zero_grid");
        check("gen_after_zero", gen_count, 1);

        src_hblinker();
        exp_vblinker();
        run_sweep(0);
        check_grid("blinker_vertical");
        check("gen_after_blinker1", gen_count, 2);

        for (int unsigned i = 0; i < TCELLS; i++) src[i] = dst[i];
        exp_hblinker();
        run_sweep(0);
        check_grid("blinker_horizontal");
        check("gen_after_blinker2", gen_count, 3);

        src_fill(1'b0);
        src[idx(TW - 1, TH - 1)] = 1'b1;
        src[idx(0, TH - 1)]      = 1'b1;
        src[idx(TW - 1, 0)]      = 1'b1;
        src[idx(0, 0)]           = 1'b1;
        exp_fill(1'b0);
        expv[idx(TW - 1, TH - 1)] = 1'b1;
        expv[idx(0, TH - 1)]      = 1'b1;
        expv[idx(TW - 1, 0)]      = 1'b1;
        expv[idx(0, 0)]           = 1'b1;
        run_sweep(0);
        check_grid("corner_block");
        check("gen_after_corner", gen_count, 4);

        src_fill(1'b1);
        exp_fill(1'b0);
        run_sweep(0);
        check_grid("all_ones");
        check("gen_after_ones", gen_count, 5);

        src_hblinker();
        exp_vblinker();
        run_sweep(1000);
        check_grid("restart_ignored");
        check("gen_after_restart", gen_count, 6);

        src_fill(1'b0);
        sweep_id++;
        @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        repeat (1999) @(negedge aclk);
        check("busy_before_reset", busy, 1);
        #2 aresetn = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_done", done, 0);
        check("abort_gen_count", gen_count, 0);
        w_snap = writes;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (60) @(negedge aclk);
        check("no_writes_after_reset", writes - w_snap, 0);
        check("idle_after_reset", busy, 0);

        src_hblinker();
        exp_vblinker();
        run_sweep(0);
        check_grid("fresh_after_reset");
        check("gen_after_fresh", gen_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
